// File: rtl/mem_size_unit_pkg.sv
// Shared encodings for the load/store size unit: access sizes, FSM states
// and the bytes-per-word helper used to size lane offsets.
package mem_size_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        WRITE   = 2'b10,
        RESP    = 2'b11
    } state_t;

    // log2 of the number of bytes in a DATA_W-bit word (2 for 32, 3 for 64)
    function automatic int bytes_log2(input int data_w);
        int n;
        n = 0;
        while ((8 << n) < data_w) n++;
        return n;
    endfunction

endpackage

// File: rtl/mem_size_unit_if.sv
// Datapath request/response and word-memory signals of the size unit.
// master = datapath plus memory side, slave = the size unit itself.
interface mem_size_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_size_unit_lane_align.sv
// Combinational byte-lane steering: extracts and extends load fields from a
// memory word, and merges store bytes into a memory word. Lane o of the word
// is bits [8o+7:8o]; SWAP_BYTES selects whether the lowest-address lane is
// the most significant byte of the register value.
module lane_align
    import mem_size_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SWAP_BYTES = 1
) (
    input  logic [1:0]                    size,
    input  logic [bytes_log2(DATA_W)-1:0] offset,
    input  logic                          sign_ext,
    input  logic [DATA_W-1:0]             rd_word,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             ld_data,
    output logic [DATA_W-1:0]             merged
);
    localparam int NB = DATA_W / 8;

    logic [3:0] n_bytes;
    int         top_lane;
    logic       fill;

    assign n_bytes  = 4'd1 << size;
    // Lane holding the sign bit; masking keeps illegal sizes in range
    assign top_lane = (SWAP_BYTES != 0) ? int'(offset)
                                        : ((int'(offset) + int'(n_bytes) - 1) & (NB - 1));
    assign fill     = sign_ext & rd_word[8*top_lane + 7];

    // Load path: gather 2^size lanes into the low bytes, then extend
    always_comb begin
        ld_data = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < int'(n_bytes)) begin
                if (SWAP_BYTES != 0)
                    ld_data[8*j +: 8] = rd_word[8*((int'(offset) + int'(n_bytes) - 1 - j) & (NB - 1)) +: 8];
                else
                    ld_data[8*j +: 8] = rd_word[8*((int'(offset) + j) & (NB - 1)) +: 8];
            end else begin
                ld_data[8*j +: 8] = {8{fill}};
            end
        end
    end

    // Store path: overwrite the selected lanes with the low bytes of wdata
    always_comb begin
        merged = rd_word;
        for (int l = 0; l < NB; l++) begin
            if ((l >= int'(offset)) && (l < int'(offset) + int'(n_bytes))) begin
                if (SWAP_BYTES != 0)
                    merged[8*l +: 8] = wdata[8*((int'(n_bytes) - 1 - (l - int'(offset))) & (NB - 1)) +: 8];
                else
                    merged[8*l +: 8] = wdata[8*((l - int'(offset)) & (NB - 1)) +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_size_unit.sv
// Sequential load/store size unit. One request at a time: loads read the
// aligned word and extract the field, sub-word stores read-modify-write,
// full-width stores write directly, illegal accesses answer with an error
// without touching memory.
module mem_size_unit
    import mem_size_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int SWAP_BYTES = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_size_unit_if.slave bus
);
    localparam int         OFF_W    = bytes_log2(DATA_W);
    localparam logic [1:0] FULL_SZ  = 2'(OFF_W);
    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        cnt;

    // request fields held for the whole transaction
    logic              wr_q;
    logic              sgn_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              acc_mis;
    logic              acc_err;
    logic              acc_full;

    logic [1:0]        al_size;
    logic [OFF_W-1:0]  al_off;
    logic              al_sgn;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] merged;

    logic              ready;
    logic              mem_wr_nx;
    logic              resp_valid_nx;
    logic              resp_err_nx;
    logic [DATA_W-1:0] rdata_nx;
    logic [DATA_W-1:0] wdata_nx;

    logic              mem_wr_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [ADDR_W-1:0] mem_addr_r;

    assign accept   = ready && bus.req_valid;
    assign acc_full = (bus.req_size == FULL_SZ);

    // Alignment check of the incoming request against its own size
    always_comb begin
        case (bus.req_size)
            SZ_B:    acc_mis = 1'b0;
            SZ_H:    acc_mis = bus.req_addr[0];
            SZ_W:    acc_mis = |bus.req_addr[1:0];
            default: acc_mis = |bus.req_addr[2:0];
        endcase
    end

    assign acc_err = acc_mis || ((OFF_W == 2) && (bus.req_size == SZ_D));

    // A full-width store goes straight from IDLE to WRITE, so lane steering
    // must see the live request there; every other use is after the latch.
    assign al_size  = (state == IDLE) ? bus.req_size   : size_q;
    assign al_off   = (state == IDLE) ? bus.req_addr[OFF_W-1:0] : off_q;
    assign al_sgn   = (state == IDLE) ? bus.req_signed : sgn_q;
    assign al_wdata = (state == IDLE) ? bus.req_wdata  : wdata_q;

    lane_align #(
        .DATA_W     (DATA_W),
        .SWAP_BYTES (SWAP_BYTES)
    ) u_lane_align (
        .size     (al_size),
        .offset   (al_off),
        .sign_ext (al_sgn),
        .rd_word  (bus.mem_rdata),
        .wdata    (al_wdata),
        .ld_data  (ld_data),
        .merged   (merged)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (acc_err)                        state_nx = RESP;
                    else if (bus.req_write && acc_full) state_nx = WRITE;
                    else                                state_nx = RD_WAIT;
                end
            end
            RD_WAIT: if (cnt == 2'd0) state_nx = wr_q ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: ready decode plus next values of the registered outputs
    always_comb begin
        ready         = (state == IDLE);
        mem_wr_nx     = (state_nx == WRITE);
        resp_valid_nx = (state_nx == RESP);
        resp_err_nx   = resp_valid_nx && ((state == IDLE) ? acc_err : err_q);
        rdata_nx      = ((state == RD_WAIT) && (state_nx == RESP)) ? ld_data : '0;
        wdata_nx      = mem_wr_nx ? merged : mem_wdata_r;
    end

    // Registered outputs, memory address and latency counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= 2'd0;
            mem_wr_r     <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
            mem_wdata_r  <= '0;
            mem_addr_r   <= '0;
        end else begin
            mem_wr_r     <= mem_wr_nx;
            resp_valid_r <= resp_valid_nx;
            resp_err_r   <= resp_err_nx;
            resp_rdata_r <= rdata_nx;
            mem_wdata_r  <= wdata_nx;
            if (accept) begin
                mem_addr_r <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                cnt        <= CNT_INIT;
            end else if ((state == RD_WAIT) && (cnt != 2'd0)) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    // Request latch; data only, so it needs no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.req_write;
            size_q  <= bus.req_size;
            sgn_q   <= bus.req_signed;
            off_q   <= bus.req_addr[OFF_W-1:0];
            wdata_q <= bus.req_wdata;
            err_q   <= acc_err;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wr     = mem_wr_r;
    assign bus.mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_mem_size_unit.sv
// Bench for mem_size_unit: a 32-bit/latency-1 and a 64-bit/latency-3 unit,
// both big-endian view, driven from a table of directed transactions plus a
// reset-abort sequence.
module tb_mem_size_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_size_unit_if #(.DATA_W(32), .ADDR_W(32)) if32 ();
    mem_size_unit_if #(.DATA_W(64), .ADDR_W(32)) if64 ();

    mem_size_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1), .SWAP_BYTES(1)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32.slave)
    );

    mem_size_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(3), .SWAP_BYTES(1)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (if64.slave)
    );

    // 32-bit memory: one-cycle latency, data valid for the address presented
    always_comb if32.mem_rdata = (if32.mem_addr == 32'h100) ? 32'h80FF7F01 : 32'hDEADBEEF;

    // 64-bit memory: three-cycle latency via two extra delay stages
    logic [63:0] p1, p2;
    always @(posedge clk) begin
        p1 <= (if64.mem_addr == 32'h200) ? 64'h8877665544332211 : 64'hDEADBEEFCAFEF00D;
        p2 <= p1;
    end
    assign if64.mem_rdata = p2;

    typedef struct {
        string       name;
        bit          w64;
        bit          wr;
        logic [1:0]  sz;
        bit          sg;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        int          exp_nwr;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input bit w64, input bit wr, input logic [1:0] sz,
                                input bit sg, input logic [31:0] a, input logic [63:0] wd,
                                input logic [63:0] er, input bit ee, input int el, input int enw,
                                input logic [63:0] ew);
        vec_t v;
        v.name = n; v.w64 = w64; v.wr = wr; v.sz = sz; v.sg = sg; v.addr = a; v.wd = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_nwr = enw; v.exp_wdata = ew;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w64, input logic v, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [63:0] wd);
        if (w64) begin
            if64.req_valid = v; if64.req_write = wr; if64.req_size = sz;
            if64.req_signed = sg; if64.req_addr = a; if64.req_wdata = wd;
        end else begin
            if32.req_valid = v; if32.req_write = wr; if32.req_size = sz;
            if32.req_signed = sg; if32.req_addr = a; if32.req_wdata = wd[31:0];
        end
    endtask

    task automatic txn(input vec_t v);
        logic [63:0] rd, wds;
        logic        er, rdy, rv;
        int          lat, nwr;
        @(negedge clk);
        rdy = v.w64 ? if64.req_ready : if32.req_ready;
        check({v.name, "/ready"}, 64'(rdy), 64'd1);
        drive(v.w64, 1'b1, v.wr, v.sz, v.sg, v.addr, v.wd);
        @(posedge clk);
        #1;
        // scramble the fields after accept: the unit must work from its latch
        drive(v.w64, 1'b0, ~v.wr, ~v.sz, ~v.sg, ~v.addr, ~v.wd);
        lat = 0; nwr = 0; rd = '0; er = 1'b0; wds = '0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (v.w64) begin
                if (if64.mem_wr) begin nwr++; wds = if64.mem_wdata; end
                if (if64.resp_valid) begin lat = k; rd = if64.resp_rdata; er = if64.resp_err; end
            end else begin
                if (if32.mem_wr) begin nwr++; wds = {32'h0, if32.mem_wdata}; end
                if (if32.resp_valid) begin lat = k; rd = {32'h0, if32.resp_rdata}; er = if32.resp_err; end
            end
        end
        check({v.name, "/latency"}, 64'(lat), 64'(v.exp_lat));
        check({v.name, "/rdata"}, rd, v.exp_rdata);
        check({v.name, "/err"}, 64'(er), 64'(v.exp_err));
        check({v.name, "/mem_wr_count"}, 64'(nwr), 64'(v.exp_nwr));
        if (v.exp_nwr != 0) check({v.name, "/mem_wdata"}, wds, v.exp_wdata);
        @(negedge clk);
        rv  = v.w64 ? if64.resp_valid : if32.resp_valid;
        rdy = v.w64 ? if64.req_ready : if32.req_ready;
        check({v.name, "/resp_pulse_ready"}, {62'd0, rv, rdy}, 64'd1);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst/ready32", 64'(if32.req_ready), 64'd1);
        check("rst/ready64", 64'(if64.req_ready), 64'd1);
        check("rst/resp_valid", 64'(if32.resp_valid), 64'd0);
        check("rst/resp_err", 64'(if32.resp_err), 64'd0);
        check("rst/resp_rdata", 64'(if32.resp_rdata), 64'd0);
        check("rst/mem_wr", 64'(if32.mem_wr), 64'd0);
        check("rst/mem_addr", 64'(if32.mem_addr), 64'd0);
        check("rst/mem_wdata", 64'(if32.mem_wdata), 64'd0);
        reset = 1'b0;

        //   name        w64 wr  size   sg  addr          wdata                   rdata                   err lat nwr wdata_exp
        add("lb_103",     0, 0, 2'b00, 1, 32'h103, 64'h0,                 64'h00000000FFFFFF80,    0, 2, 0, 64'h0);
        add("lbu_101",    0, 0, 2'b00, 0, 32'h101, 64'h0,                 64'h000000000000007F,    0, 2, 0, 64'h0);
        add("lb_100",     0, 0, 2'b00, 1, 32'h100, 64'h0,                 64'h0000000000000001,    0, 2, 0, 64'h0);
        add("lh_102",     0, 0, 2'b01, 1, 32'h102, 64'h0,                 64'h00000000FFFFFF80,    0, 2, 0, 64'h0);
        add("lhu_100",    0, 0, 2'b01, 0, 32'h100, 64'h0,                 64'h000000000000017F,    0, 2, 0, 64'h0);
        add("lw_100",     0, 0, 2'b10, 1, 32'h100, 64'h0,                 64'h00000000017FFF80,    0, 2, 0, 64'h0);
        add("sb_102",     0, 1, 2'b00, 0, 32'h102, 64'h000000AB,          64'h0,                   0, 3, 1, 64'h80AB7F01);
        add("sh_102",     0, 1, 2'b01, 0, 32'h102, 64'hFFFF1234,          64'h0,                   0, 3, 1, 64'h34127F01);
        add("sw_100",     0, 1, 2'b10, 0, 32'h100, 64'h11223344,          64'h0,                   0, 2, 1, 64'h44332211);
        add("lh_101_mis", 0, 0, 2'b01, 1, 32'h101, 64'h0,                 64'h0,                   1, 1, 0, 64'h0);
        add("lw_102_mis", 0, 0, 2'b10, 0, 32'h102, 64'h0,                 64'h0,                   1, 1, 0, 64'h0);
        add("ld32_ill",   0, 0, 2'b11, 0, 32'h100, 64'h0,                 64'h0,                   1, 1, 0, 64'h0);
        add("sd32_ill",   0, 1, 2'b11, 0, 32'h100, 64'h0,                 64'h0,                   1, 1, 0, 64'h0);
        add("ld64_200",   1, 0, 2'b11, 1, 32'h200, 64'h0,                 64'h1122334455667788,    0, 4, 0, 64'h0);
        add("lw64_204",   1, 0, 2'b10, 1, 32'h204, 64'h0,                 64'h0000000055667788,    0, 4, 0, 64'h0);
        add("lb64_207",   1, 0, 2'b00, 1, 32'h207, 64'h0,                 64'hFFFFFFFFFFFFFF88,    0, 4, 0, 64'h0);
        add("sb64_203",   1, 1, 2'b00, 0, 32'h203, 64'h00000000000000AB,  64'h0,                   0, 5, 1, 64'h88776655AB332211);
        add("sd64_201",   1, 1, 2'b11, 0, 32'h201, 64'h0,                 64'h0,                   1, 1, 0, 64'h0);
        add("sd64_200",   1, 1, 2'b11, 0, 32'h200, 64'h0102030405060708,  64'h0,                   0, 2, 1, 64'h0807060504030201);

        foreach (vecs[i]) txn(vecs[i]);

        // reset while a byte store waits for its read: write and response dropped
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h102, 64'h000000CD);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort/ready", 64'(if32.req_ready), 64'd1);
        check("abort/mem_wr", 64'(if32.mem_wr), 64'd0);
        check("abort/resp_valid", 64'(if32.resp_valid), 64'd0);
        check("abort/mem_addr", 64'(if32.mem_addr), 64'd0);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (if32.mem_wr || if32.resp_valid || !if32.req_ready) bad++;
        end
        check("abort/quiet_after", 64'(bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
